// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types for the 32-bit ALU initiator: opcodes, flag bit positions,
// branch conditions and the sequencer state encoding.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int unsigned ALU_W  = 32;
  localparam int unsigned WIDE_W = 64;

  typedef enum logic [3:0] {
    OP_ADD    = 4'h0,
    OP_SUB    = 4'h1,
    OP_AND    = 4'h2,
    OP_OR     = 4'h3,
    OP_XOR    = 4'h4,
    OP_SRL    = 4'h5,
    OP_SRA    = 4'h6,
    OP_SLL    = 4'h7,
    OP_CARRY  = 4'h8,
    OP_BORROW = 4'h9
  } alu_op_e;

  // Bit positions inside the 4-bit {ovf, sign, borrow, zero} flag vector.
  localparam int unsigned FLAG_ZERO   = 0;
  localparam int unsigned FLAG_BORROW = 1;
  localparam int unsigned FLAG_SIGN   = 2;
  localparam int unsigned FLAG_OVF    = 3;

  typedef enum logic [2:0] {
    COND_NEVER  = 3'd0,
    COND_EQ     = 3'd1,
    COND_NE     = 3'd2,
    COND_LTU    = 3'd3,
    COND_GEU    = 3'd4,
    COND_LT     = 3'd5,
    COND_GE     = 3'd6,
    COND_ALWAYS = 3'd7
  } cond_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EXEC = 3'd1,
    ST_P1   = 3'd2,
    ST_P2   = 3'd3,
    ST_P3   = 3'd4,
    ST_P4   = 3'd5,
    ST_RESP = 3'd6
  } seq_state_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_sequencer_if
// Bundles the request handshake, response handshake and the external ALU
// connection of alu_sequencer.
//   slave  : the sequencer's view (takes requests, returns responses, drives ALU)
//   master : the requester/consumer/ALU side
// -----------------------------------------------------------------------------
interface alu_sequencer_if;

  // Request channel
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic        req_wide;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [2:0]  req_cond;

  // Response channel
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_res;
  logic [3:0]  rsp_flags;
  logic        rsp_cond;
  logic        rsp_err;

  // External combinational ALU
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_res;
  logic [3:0]  alu_flags;

  modport slave (
    input  req_valid, req_op, req_wide, req_a, req_b, req_cond,
    output req_ready,
    output rsp_valid, rsp_res, rsp_flags, rsp_cond, rsp_err,
    input  rsp_ready,
    output alu_a, alu_b, alu_op,
    input  alu_res, alu_flags
  );

  modport master (
    output req_valid, req_op, req_wide, req_a, req_b, req_cond,
    input  req_ready,
    input  rsp_valid, rsp_res, rsp_flags, rsp_cond, rsp_err,
    output rsp_ready,
    input  alu_a, alu_b, alu_op,
    output alu_res, alu_flags
  );

endinterface

// File: rtl/alu_cond_eval.sv
// -----------------------------------------------------------------------------
// alu_cond_eval
// Combinational branch-condition evaluator over {ovf, sign, borrow, zero}.
//   flags_i [3:0] : flag vector
//   cond_i  [2:0] : condition code (NEVER, EQ, NE, LTU, GEU, LT, GE, ALWAYS)
//   taken_o       : condition result
// -----------------------------------------------------------------------------
module alu_cond_eval
  import alu_pkg::*;
(
  input  logic [3:0] flags_i,
  input  logic [2:0] cond_i,
  output logic       taken_o
);

  logic signed_lt;
  assign signed_lt = flags_i[FLAG_SIGN] ^ flags_i[FLAG_OVF];

  always_comb begin
    taken_o = 1'b0;
    case (cond_e'(cond_i))
      COND_NEVER:  taken_o = 1'b0;
      COND_EQ:     taken_o = flags_i[FLAG_ZERO];
      COND_NE:     taken_o = !flags_i[FLAG_ZERO];
      COND_LTU:    taken_o = flags_i[FLAG_BORROW];
      COND_GEU:    taken_o = !flags_i[FLAG_BORROW];
      COND_LT:     taken_o = signed_lt;
      COND_GE:     taken_o = !signed_lt;
      COND_ALWAYS: taken_o = 1'b1;
      default:     taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
// Initiator for an external 32-bit combinational ALU. Accepts one request at a
// time, drives the ALU from registers, and returns result, flags and an
// evaluated condition. 64-bit add/sub runs as four ALU passes:
//   P1 lo op, P2 lo carry/borrow, P3 hi op, P4 (hi result) op carry.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : alu_sequencer_if.slave (request, response and ALU signals)
// -----------------------------------------------------------------------------
module alu_sequencer
  import alu_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  alu_sequencer_if.slave bus
);

  seq_state_e  state_q, state_d;
  logic [63:0] a_q, a_d;
  logic [63:0] b_q, b_d;
  logic        sub_q, sub_d;       // wide op is subtract
  logic [2:0]  cond_q, cond_d;
  logic        err_q, err_d;       // illegal wide request in flight
  logic [31:0] res_lo_q, res_lo_d;
  logic        carry_q, carry_d;   // carry/borrow out of the low half
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [63:0] rsp_res_q, rsp_res_d;
  logic [3:0]  rsp_flags_q, rsp_flags_d;
  logic        rsp_cond_q, rsp_cond_d;
  logic        rsp_err_q, rsp_err_d;

  // Flags being captured this cycle; the evaluator sees the same value so the
  // condition lands in the response register together with the flags.
  logic [3:0]  cap_flags;
  logic        cap_taken;
  logic [63:0] wide_res;

  assign wide_res = {bus.alu_res, res_lo_q};

  always_comb begin
    cap_flags = 4'h0;
    if (state_q == ST_EXEC && !err_q) begin
      cap_flags = bus.alu_flags;
    end else if (state_q == ST_P4) begin
      cap_flags[FLAG_ZERO] = (wide_res == 64'h0);
      cap_flags[FLAG_SIGN] = bus.alu_res[31];
    end
  end

  alu_cond_eval u_cond_eval (
    .flags_i (cap_flags),
    .cond_i  (cond_q),
    .taken_o (cap_taken)
  );

  // NOTE: every _d is defaulted to its _q first, so no path through the case
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sub_d       = sub_q;
    cond_d      = cond_q;
    err_d       = err_q;
    res_lo_d    = res_lo_q;
    carry_d     = carry_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_res_d   = rsp_res_q;
    rsp_flags_d = rsp_flags_q;
    rsp_cond_d  = rsp_cond_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          a_d    = bus.req_a;
          b_d    = bus.req_b;
          cond_d = bus.req_cond;
          sub_d  = bus.req_op[0];
          err_d  = 1'b0;
          if (!bus.req_wide) begin
            state_d  = ST_EXEC;
            alu_a_d  = bus.req_a[31:0];
            alu_b_d  = bus.req_b[31:0];
            alu_op_d = bus.req_op;
          end else if (bus.req_op == OP_ADD || bus.req_op == OP_SUB) begin
            state_d  = ST_P1;
            alu_a_d  = bus.req_a[31:0];
            alu_b_d  = bus.req_b[31:0];
            alu_op_d = bus.req_op;
          end else begin
            // Illegal wide op: spend one idle pass (ALU left at 0) so the
            // error response keeps the same latency as a narrow op.
            state_d = ST_EXEC;
            err_d   = 1'b1;
          end
        end
      end

      ST_EXEC: begin
        rsp_valid_d = 1'b1;
        rsp_res_d   = err_q ? 64'h0 : {32'h0, bus.alu_res};
        rsp_flags_d = cap_flags;
        rsp_cond_d  = err_q ? 1'b0 : cap_taken;
        rsp_err_d   = err_q;
        alu_a_d     = '0;
        alu_b_d     = '0;
        alu_op_d    = '0;
        state_d     = ST_RESP;
      end

      ST_P1: begin
        res_lo_d = bus.alu_res;
        alu_op_d = sub_q ? OP_BORROW : OP_CARRY;
        state_d  = ST_P2;
      end

      ST_P2: begin
        carry_d  = bus.alu_res[0];
        alu_a_d  = a_q[63:32];
        alu_b_d  = b_q[63:32];
        alu_op_d = sub_q ? OP_SUB : OP_ADD;
        state_d  = ST_P3;
      end

      ST_P3: begin
        // Fold the low-half carry/borrow into the high partial result.
        alu_a_d = bus.alu_res;
        alu_b_d = {31'h0, carry_q};
        state_d = ST_P4;
      end

      ST_P4: begin
        rsp_valid_d = 1'b1;
        rsp_res_d   = wide_res;
        rsp_flags_d = cap_flags;
        rsp_cond_d  = cap_taken;
        rsp_err_d   = 1'b0;
        alu_a_d     = '0;
        alu_b_d     = '0;
        alu_op_d    = '0;
        state_d     = ST_RESP;
      end

      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      cond_q      <= '0;
      err_q       <= 1'b0;
      res_lo_q    <= '0;
      carry_q     <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_res_q   <= '0;
      rsp_flags_q <= '0;
      rsp_cond_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sub_q       <= sub_d;
      cond_q      <= cond_d;
      err_q       <= err_d;
      res_lo_q    <= res_lo_d;
      carry_q     <= carry_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_res_q   <= rsp_res_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_cond_q  <= rsp_cond_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_res   = rsp_res_q;
  assign bus.rsp_flags = rsp_flags_q;
  assign bus.rsp_cond  = rsp_cond_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_op    = alu_op_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
// Self-checking bench: models the external ALU, drives directed and random
// transactions, and compares every response with an arithmetic reference.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- external ALU model ----------------
  function automatic logic [31:0] alu_fn(input logic [31:0] a, b, input logic [3:0] op);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a >> b[4:0];
      4'd6: return $unsigned($signed(a) >>> b[4:0]);
      4'd7: return a << b[4:0];
      4'd8: return {31'h0, s[32]};
      4'd9: return {31'h0, (a < b)};
      default: return 32'h0;
    endcase
  endfunction

  // {ovf, sign, borrow, zero} of a - b
  function automatic logic [3:0] sub_flags(input logic [31:0] a, b);
    logic [31:0] d;
    d = a - b;
    return {(a[31] != b[31]) && (d[31] != a[31]), d[31], (a < b), (d == 32'h0)};
  endfunction

  always_comb begin
    bus.alu_res   = alu_fn(bus.alu_a, bus.alu_b, bus.alu_op);
    bus.alu_flags = sub_flags(bus.alu_a, bus.alu_b);
  end

  function automatic logic cond_fn(input logic [3:0] f, input logic [2:0] c);
    case (c)
      3'd0: return 1'b0;
      3'd1: return f[0];
      3'd2: return !f[0];
      3'd3: return f[1];
      3'd4: return !f[1];
      3'd5: return f[2] ^ f[3];
      3'd6: return !(f[2] ^ f[3]);
      default: return 1'b1;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Last observed response, for the hand-computed expectations.
  logic [63:0] obs_res;
  logic [3:0]  obs_flags;
  logic        obs_cond;
  logic        obs_err;
  int          obs_lat;

  task automatic do_txn(input logic [3:0] op, input logic wide, input logic [63:0] a, b,
                        input logic [2:0] cond, input int hold, input string name);
    logic [63:0] e_res, sum;
    logic [3:0]  e_flags;
    logic        e_cond, e_err;
    int          e_lat, lat;
    logic [3:0]  ops[$];
    bit          timed_out;

    // Reference
    e_err = 1'b0;
    if (wide && op > 4'd1) begin
      e_err = 1'b1; e_res = '0; e_flags = '0; e_lat = 2;
    end else if (wide) begin
      sum     = op[0] ? a - b : a + b;
      e_res   = sum;
      e_flags = {1'b0, sum[63], 1'b0, (sum == 64'h0)};
      e_lat   = 5;
    end else begin
      e_res   = {32'h0, alu_fn(a[31:0], b[31:0], op)};
      e_flags = sub_flags(a[31:0], b[31:0]);
      e_lat   = 2;
    end
    e_cond = e_err ? 1'b0 : cond_fn(e_flags, cond);

    @(negedge clk);
    check({name, " req_ready"}, 64'(bus.req_ready), 64'd1);
    check({name, " idle alu"}, {bus.alu_a, bus.alu_b}, 64'h0);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_wide = wide;
    bus.req_a = a; bus.req_b = b; bus.req_cond = cond; bus.rsp_ready = 1'b0;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;

    lat = 1; timed_out = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin timed_out = 1'b0; break; end
      ops.push_back(bus.alu_op);
      if (bus.req_ready !== 1'b0) check({name, " busy ready"}, 64'(bus.req_ready), 64'd0);
      lat++;
    end
    if (timed_out) begin
      check({name, " timeout"}, 64'd1, 64'd0);
      return;
    end

    obs_res = bus.rsp_res; obs_flags = bus.rsp_flags; obs_cond = bus.rsp_cond;
    obs_err = bus.rsp_err; obs_lat = lat;
    check({name, " res"},   bus.rsp_res, e_res);
    check({name, " flags"}, 64'(bus.rsp_flags), 64'(e_flags));
    check({name, " cond"},  64'(bus.rsp_cond), 64'(e_cond));
    check({name, " err"},   64'(bus.rsp_err), 64'(e_err));
    check({name, " lat"},   64'(lat), 64'(e_lat));
    if (wide && !e_err) begin
      check({name, " nops"}, 64'(ops.size()), 64'd4);
      if (ops.size() == 4) begin
        check({name, " op1"}, 64'(ops[0]), 64'(op));
        check({name, " op2"}, 64'(ops[1]), 64'(op + 4'd8));
        check({name, " op3"}, 64'(ops[2]), 64'(op));
        check({name, " op4"}, 64'(ops[3]), 64'(op));
      end
    end

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, " hold"}, {bus.rsp_valid, bus.req_ready, bus.rsp_err, bus.rsp_cond, bus.rsp_flags},
            {1'b1, 1'b0, e_err, e_cond, e_flags});
      check({name, " hold res"}, bus.rsp_res, e_res);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check({name, " drop"}, {bus.rsp_valid, bus.req_ready}, {1'b0, 1'b1});
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " rsp"}, {bus.rsp_valid, bus.rsp_err, bus.rsp_cond, bus.rsp_flags}, 64'h0);
    check({name, " res"}, bus.rsp_res, 64'h0);
    check({name, " alu"}, {bus.alu_a, bus.alu_b, bus.alu_op}, 68'h0);
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic [3:0]  rop;
    logic        rw;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_wide = 1'b0;
    bus.req_a = '0; bus.req_b = '0; bus.req_cond = '0; bus.rsp_ready = 1'b0;

    // Reset state
    #12;
    check_reset_outputs("reset");
    @(negedge clk) rst = 1'b0;
    #1 check("ready after reset", 64'(bus.req_ready), 64'd1);

    // Narrow add 5+7, cond LT
    do_txn(4'd0, 1'b0, 64'd5, 64'd7, 3'd5, 0, "add57");
    check("add57 lit res", obs_res, 64'd12);
    check("add57 lit flags", 64'(obs_flags), 64'b0110);
    check("add57 lit cond", 64'(obs_cond), 64'd1);
    check("add57 lit lat", 64'(obs_lat), 64'd2);

    // Narrow compare, EQ then NE
    do_txn(4'd1, 1'b0, 64'h1234, 64'h1234, 3'd1, 0, "cmp_eq");
    check("cmp_eq lit", {obs_res, obs_flags, obs_cond}, {64'h0, 4'b0001, 1'b1});
    do_txn(4'd1, 1'b0, 64'h1234, 64'h1234, 3'd2, 0, "cmp_ne");
    check("cmp_ne lit cond", 64'(obs_cond), 64'd0);

    // Wide add / sub
    do_txn(4'd0, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 3'd7, 0, "wadd");
    check("wadd lit res", obs_res, 64'h0000_0001_0000_0000);
    check("wadd lit flags", 64'(obs_flags), 64'h0);
    check("wadd lit lat", 64'(obs_lat), 64'd5);
    do_txn(4'd1, 1'b1, 64'h0000_0001_0000_0000, 64'd1, 3'd1, 0, "wsub");
    check("wsub lit res", obs_res, 64'h0000_0000_FFFF_FFFF);
    do_txn(4'd1, 1'b1, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 3'd1, 0, "wsub_eq");
    check("wsub_eq lit zero", {60'h0, obs_flags, obs_cond}, {60'h0, 4'b0001, 1'b1});

    // Backpressure and illegal wide op
    do_txn(4'd0, 1'b0, 64'd100, 64'd23, 3'd4, 3, "bp");
    do_txn(4'd2, 1'b1, 64'hFFFF, 64'hFFFF, 3'd7, 1, "illegal");
    check("illegal lit", {obs_res, obs_err, obs_cond}, {64'h0, 1'b1, 1'b0});
    check("illegal lit lat", 64'(obs_lat), 64'd2);

    // Reset during P3 of a wide add
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 4'd0; bus.req_wide = 1'b1;
    bus.req_a = 64'h1111_2222_3333_4444; bus.req_b = 64'h5555_6666_7777_8888; bus.req_cond = 3'd7;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1 check_reset_outputs("mid reset");
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post reset idle", {bus.rsp_valid, bus.req_ready}, {1'b0, 1'b1});
    end
    do_txn(4'd0, 1'b0, 64'd1, 64'd1, 3'd7, 0, "after_rst");
    check("after_rst lit res", obs_res, 64'd2);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      ra = {$urandom, $urandom};
      rb = ($urandom_range(0, 3) == 0) ? ra : {$urandom, $urandom};
      rw = ($urandom_range(0, 2) == 0);
      if (rw) rop = ($urandom_range(0, 5) < 5) ? 4'($urandom_range(0, 1)) : 4'($urandom_range(2, 15));
      else    rop = 4'($urandom_range(0, 15));
      do_txn(rop, rw, ra, rb, 3'($urandom_range(0, 7)), $urandom_range(0, 3), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
